// File: rtl/model_pack.sv
`default_nettype none
// ============================================================================
//  Package     : model_pack
//  Description : Shared definitions for the TDC measurement controller:
//                FSM state encoding and default geometry constants.
//  Revision    : 1.0  initial release
// ============================================================================
package model_pack;

    // Default number of delay-chain stages (thermometer width).
    localparam int c_n_stages_default = 64;
    // Default width of the WAIT timeout counter / configuration.
    localparam int c_to_w_default     = 8;
    // Largest supported log2 of conversions per result.
    localparam int c_navg_log2_max    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESET  = 3'd1,
        ST_ARM     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_ACCUM   = 3'd5,
        ST_OUT     = 3'd6
    } meas_state_t;

endpackage
`default_nettype wire

// File: rtl/tdc_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_popcount
//  Description : Combinational population count of a thermometer word.
//                Produces the conversion code of one TDC measurement.
//  Ports       : bits  in  N_STAGES  thermometer (already polarity-corrected)
//                count out CODE_W    number of ones in bits
//  Revision    : 1.0  initial release
// ============================================================================
module tdc_popcount
    import model_pack::*;
#(
    parameter int N_STAGES = c_n_stages_default,
    parameter int CODE_W   = $clog2(N_STAGES) + 1
) (
    input  logic [N_STAGES-1:0] bits,
    output logic [CODE_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            count = count + CODE_W'(bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdc_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_meas_ctrl
//  Description : Measurement controller for a phase-reverse delay-line TDC.
//                Presets the chain, launches the start edge, waits for the
//                stop event (with optional timeout), captures the thermometer
//                code and accumulates 2^navg conversions into one result.
//  Ports       : clk            in   clock, all state on rising edge
//                rstb           in   asynchronous active-low reset
//                start          in   begin a burst (sampled in IDLE only)
//                cfg_navg_log2  in   log2 conversions per result (5..7 -> 4)
//                cfg_timeout    in   WAIT cycle limit, 0 = no timeout
//                tdc_pstb       out  active-low preset of phase-reverse flops
//                tdc_launch     out  start edge into the inverter chain
//                tdc_stop       in   synchronized stop event
//                tdc_therm      in   thermometer word from the flop bank
//                tdc_pr_clk     out  one-cycle capture pulse for the flops
//                res_data       out  accumulated sum of codes
//                res_valid      out  result valid, held until res_ready
//                res_ready      in   downstream accept
//                busy           out  high in every state except IDLE
//                timeout_err    out  sticky WAIT-timeout flag
//  Revision    : 1.0  initial release
// ============================================================================
module tdc_meas_ctrl
    import model_pack::*;
#(
    parameter int N_STAGES = c_n_stages_default,
    parameter int TO_W     = c_to_w_default,
    parameter int CODE_W   = $clog2(N_STAGES) + 1
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [2:0]           cfg_navg_log2,
    input  logic [TO_W-1:0]      cfg_timeout,
    output logic                 tdc_pstb,
    output logic                 tdc_launch,
    input  logic                 tdc_stop,
    input  logic [N_STAGES-1:0]  tdc_therm,
    output logic                 tdc_pr_clk,
    output logic [CODE_W+3:0]    res_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 timeout_err
);

    // 16 conversions of at most N_STAGES each fit in CODE_W+4 bits.
    localparam int c_acc_w = CODE_W + 4;
    localparam int c_smp_w = c_navg_log2_max + 1;

    meas_state_t            r_state;
    logic                   r_pre_done;
    logic                   r_pol;
    logic [2:0]             r_navg;
    logic [TO_W-1:0]        r_timeout;
    logic [TO_W-1:0]        r_to_cnt;
    logic [c_smp_w-1:0]     r_smp_cnt;
    logic [N_STAGES-1:0]    r_therm;
    logic [c_acc_w-1:0]     r_acc;
    logic [c_acc_w-1:0]     r_res_data;
    logic                   r_pstb;
    logic                   r_launch;
    logic                   r_pr_clk;
    logic                   r_res_valid;
    logic                   r_busy;
    logic                   r_timeout_err;

    logic [2:0]             w_navg_clamped;
    logic [TO_W-1:0]        w_to_cnt_inc;
    logic                   w_timed_out;
    logic [c_smp_w-1:0]     w_smp_cnt_inc;
    logic [c_smp_w-1:0]     w_smp_target;
    logic [N_STAGES-1:0]    w_therm_rel;
    logic [CODE_W-1:0]      w_code;
    logic [c_acc_w-1:0]     w_acc_next;

    assign w_navg_clamped = (cfg_navg_log2 > 3'(c_navg_log2_max)) ?
                            3'(c_navg_log2_max) : cfg_navg_log2;

    // The increment never wraps while a nonzero timeout is armed, because the
    // burst leaves WAIT as soon as the incremented count equals the limit.
    assign w_to_cnt_inc  = r_to_cnt + TO_W'(1);
    assign w_timed_out   = (r_timeout != '0) && (w_to_cnt_inc == r_timeout);

    assign w_smp_cnt_inc = r_smp_cnt + c_smp_w'(1);
    assign w_smp_target  = c_smp_w'(1) << r_navg;

    // The chain alternates its resting level every conversion; when the last
    // stage settled high, the next thermometer is read inverted.
    assign w_therm_rel   = r_therm ^ {N_STAGES{r_pol}};
    assign w_acc_next    = r_acc + c_acc_w'(w_code);

    tdc_popcount #(
        .N_STAGES (N_STAGES),
        .CODE_W   (CODE_W)
    ) u_popcount (
        .bits     (w_therm_rel),
        .count    (w_code)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= ST_IDLE;
            r_pre_done    <= 1'b0;
            r_pol         <= 1'b0;
            r_navg        <= '0;
            r_timeout     <= '0;
            r_to_cnt      <= '0;
            r_smp_cnt     <= '0;
            r_therm       <= '0;
            r_acc         <= '0;
            r_res_data    <= '0;
            r_pstb        <= 1'b0;
            r_launch      <= 1'b0;
            r_pr_clk      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pr_clk <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_pstb   <= 1'b1;
                    r_launch <= 1'b0;
                    r_busy   <= 1'b0;
                    if (start) begin
                        r_state       <= ST_PRESET;
                        r_pstb        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_pre_done    <= 1'b0;
                        r_acc         <= '0;
                        r_smp_cnt     <= '0;
                        r_timeout_err <= 1'b0;
                        r_navg        <= w_navg_clamped;
                        r_timeout     <= cfg_timeout;
                    end
                end

                // Preset is held low for exactly two cycles.
                ST_PRESET: begin
                    if (r_pre_done) begin
                        r_state <= ST_ARM;
                        r_pstb  <= 1'b1;
                    end else begin
                        r_pre_done <= 1'b1;
                    end
                end

                ST_ARM: begin
                    r_state  <= ST_WAIT;
                    r_launch <= 1'b1;
                    r_to_cnt <= '0;
                end

                // A stop in the same cycle as the timeout takes priority.
                ST_WAIT: begin
                    if (tdc_stop) begin
                        r_state  <= ST_CAPTURE;
                        r_pr_clk <= 1'b1;
                    end else if (w_timed_out) begin
                        r_state       <= ST_OUT;
                        r_launch      <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_res_data    <= r_acc;
                    end else begin
                        r_to_cnt <= w_to_cnt_inc;
                    end
                end

                ST_CAPTURE: begin
                    r_state  <= ST_ACCUM;
                    r_therm  <= tdc_therm;
                    r_launch <= 1'b0;
                end

                ST_ACCUM: begin
                    r_acc     <= w_acc_next;
                    r_pol     <= r_therm[N_STAGES-1];
                    r_smp_cnt <= w_smp_cnt_inc;
                    if (w_smp_cnt_inc == w_smp_target) begin
                        r_state     <= ST_OUT;
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_acc_next;
                    end else begin
                        r_state <= ST_ARM;
                    end
                end

                ST_OUT: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tdc_pstb    = r_pstb;
    assign tdc_launch  = r_launch;
    assign tdc_pr_clk  = r_pr_clk;
    assign res_data    = r_res_data;
    assign res_valid   = r_res_valid;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
